// File: rtl/bru_pkg.sv
// Shared types and helpers for the branch resolve unit: opcodes, the 2-bit BHT
// counter type and its saturating update functions.
package bru_pkg;

    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BLTZ = 6'b000001;
    localparam logic [5:0] OP_BLE  = 6'b000110;
    localparam logic [5:0] OP_BGT  = 6'b000111;

    typedef logic [1:0] cnt2_t;

    localparam cnt2_t BHT_RESET = 2'b01;

    function automatic cnt2_t sat_inc(input cnt2_t c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic cnt2_t sat_dec(input cnt2_t c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/bru_bht.sv
// Branch history table: DEPTH 2-bit saturating counters indexed by pc[IDX_W+1:2],
// one combinational read port (read-before-write) and one training write port.
module bru_bht
    import bru_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PC_W  = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [PC_W-1:0] rd_pc_i,
    output logic            rd_taken_o,
    input  logic            wr_en_i,
    input  logic [PC_W-1:0] wr_pc_i,
    input  logic            wr_taken_i
);

    localparam int IDX_W = $clog2(DEPTH);

    cnt2_t [DEPTH-1:0] tbl;
    logic  [IDX_W-1:0] rd_idx;
    logic  [IDX_W-1:0] wr_idx;

    assign rd_idx = rd_pc_i[IDX_W+1:2];
    assign wr_idx = wr_pc_i[IDX_W+1:2];

    // Prediction is the counter MSB; a same-cycle write lands at the edge, so
    // the read here always sees the pre-update value.
    assign rd_taken_o = tbl[rd_idx][1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= BHT_RESET;
        end else if (wr_en_i) begin
            tbl[wr_idx] <= wr_taken_i ? sat_inc(tbl[wr_idx]) : sat_dec(tbl[wr_idx]);
        end
    end

    logic unused_pc;
    assign unused_pc = ^{rd_pc_i[PC_W-1:IDX_W+2], rd_pc_i[1:0],
                         wr_pc_i[PC_W-1:IDX_W+2], wr_pc_i[1:0]};

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution with 1-cycle registered outcome, mispredict flush and
// BHT training. Optional perf counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 16
`ifdef BRU_PERF_CNT_EN
    ,
    parameter int CNT_W     = 32
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [5:0]        instr_op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              pred_taken_i,
    input  logic [PC_W-1:0]   lookup_pc_i,
    output logic              lookup_taken_o,
    output logic              valid_o,
    output logic              is_branch_o,
    output logic              branch_res_o,
    output logic              mispredict_o
`ifdef BRU_PERF_CNT_EN
    ,
    input  logic              perf_clr_i,
    output logic [CNT_W-1:0]  br_cnt_o,
    output logic [CNT_W-1:0]  mis_cnt_o
`endif
);

    logic is_br;
    logic taken;
    logic accept;
    logic br_upd;
    logic mis_upd;

    always_comb begin
        is_br = 1'b1;
        taken = 1'b0;
        case (instr_op_i)
            OP_BEQ:  taken = (src1_i == src2_i);
            OP_BNE:  taken = (src1_i != src2_i);
            OP_BLTZ: taken = src1_i[DATA_W-1];
            OP_BLE:  taken = ($signed(src1_i) <= $signed(src2_i));
            OP_BGT:  taken = ($signed(src1_i) >  $signed(src2_i));
            default: is_br = 1'b0;
        endcase
    end

    // An instruction arriving during the flush cycle is on the wrong path.
    assign accept  = valid_i & ~mispredict_o;
    assign br_upd  = accept & is_br;
    assign mis_upd = br_upd & (taken ^ pred_taken_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o      <= 1'b0;
            is_branch_o  <= 1'b0;
            branch_res_o <= 1'b0;
            mispredict_o <= 1'b0;
        end else begin
            valid_o      <= accept;
            is_branch_o  <= br_upd;
            branch_res_o <= br_upd & taken;
            mispredict_o <= mis_upd;
        end
    end

    bru_bht #(
        .DEPTH (BHT_DEPTH),
        .PC_W  (PC_W)
    ) u_bht (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_pc_i    (lookup_pc_i),
        .rd_taken_o (lookup_taken_o),
        .wr_en_i    (br_upd),
        .wr_pc_i    (pc_i),
        .wr_taken_i (taken)
    );

`ifdef BRU_PERF_CNT_EN
    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i || perf_clr_i) begin
            br_cnt_o  <= '0;
            mis_cnt_o <= '0;
        end else begin
            if (br_upd  && !(&br_cnt_o))  br_cnt_o  <= br_cnt_o  + 1'b1;
            if (mis_upd && !(&mis_cnt_o)) mis_cnt_o <= mis_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected results queued at drive time,
// popped and compared one cycle later; BHT prediction tracked by a reference table.
module tb_branch_resolve_unit;

    localparam logic [5:0] BEQ = 6'd4, BNE = 6'd5, BLTZ = 6'd1, BLE = 6'd6, BGT = 6'd7;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [5:0]  instr_op_i;
    logic [31:0] src1_i, src2_i, pc_i, lookup_pc_i;
    logic        pred_taken_i;
    logic        lookup_taken_o, valid_o, is_branch_o, branch_res_o, mispredict_o;
`ifdef BRU_PERF_CNT_EN
    logic        perf_clr_i;
    logic [31:0] br_cnt_o, mis_cnt_o;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .instr_op_i     (instr_op_i),
        .src1_i         (src1_i),
        .src2_i         (src2_i),
        .pc_i           (pc_i),
        .pred_taken_i   (pred_taken_i),
        .lookup_pc_i    (lookup_pc_i),
        .lookup_taken_o (lookup_taken_o),
        .valid_o        (valid_o),
        .is_branch_o    (is_branch_o),
        .branch_res_o   (branch_res_o),
        .mispredict_o   (mispredict_o)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_clr_i     (perf_clr_i),
        .br_cnt_o       (br_cnt_o),
        .mis_cnt_o      (mis_cnt_o)
`endif
    );

    typedef struct {
        logic v;
        logic b;
        logic r;
        logic m;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   bht_m[16];
    logic m_mis;
    int   br_m, mis_m;
    logic clr_req = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Returns {is_branch, taken}
    function automatic logic [1:0] ref_dec(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            BEQ:     return {1'b1, a == b};
            BNE:     return {1'b1, a != b};
            BLTZ:    return {1'b1, $signed(a) < 0};
            BLE:     return {1'b1, $signed(a) <= $signed(b)};
            BGT:     return {1'b1, $signed(a) > $signed(b)};
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 1;
        m_mis = 1'b0;
        br_m  = 0;
        mis_m = 0;
        sbq.delete();
    endtask

    task automatic do_reset();
        rst_i = 1'b1; valid_i = 1'b0; instr_op_i = '0; src1_i = '0; src2_i = '0;
        pc_i = '0; pred_taken_i = 1'b0; lookup_pc_i = 32'h40;
`ifdef BRU_PERF_CNT_EN
        perf_clr_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
    endtask

    // Drive one EX instruction at a negedge; lookup uses the same PC so the
    // lookup check exercises read-before-write on the updated entry.
    task automatic step(input logic v, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic p);
        logic [1:0] d;
        logic       acc;
        exp_t       e;
        int         idx;
        valid_i = v; instr_op_i = op; src1_i = a; src2_i = b; pc_i = pc;
        pred_taken_i = p; lookup_pc_i = pc;
`ifdef BRU_PERF_CNT_EN
        perf_clr_i = clr_req;
`endif
        #1;
        idx = int'(pc[5:2]);
        chk("lookup", {31'd0, lookup_taken_o}, {31'd0, bht_m[idx] >= 2});
        d   = ref_dec(op, a, b);
        acc = v && !m_mis;
        e.v = acc;
        e.b = acc && d[1];
        e.r = e.b && d[0];
        e.m = e.b && (d[0] != p);
        sbq.push_back(e);
        if (e.b) begin
            if (d[0]) bht_m[idx] = (bht_m[idx] == 3) ? 3 : bht_m[idx] + 1;
            else      bht_m[idx] = (bht_m[idx] == 0) ? 0 : bht_m[idx] - 1;
        end
        if (clr_req) begin
            br_m = 0; mis_m = 0;
        end else begin
            if (e.b) br_m++;
            if (e.m) mis_m++;
        end
        m_mis = e.m;
        @(posedge clk);
        @(negedge clk);
        e = sbq.pop_front();
        chk("valid_o",      {31'd0, valid_o},      {31'd0, e.v});
        chk("is_branch_o",  {31'd0, is_branch_o},  {31'd0, e.b});
        chk("branch_res_o", {31'd0, branch_res_o}, {31'd0, e.r});
        chk("mispredict_o", {31'd0, mispredict_o}, {31'd0, e.m});
`ifdef BRU_PERF_CNT_EN
        chk("br_cnt_o",  br_cnt_o,  br_m);
        chk("mis_cnt_o", mis_cnt_o, mis_m);
`endif
    endtask

    logic [31:0] vals [6] = '{32'h0, 32'h1, 32'h5, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [5:0]  ops  [7] = '{BEQ, BNE, BLTZ, BLE, BGT, 6'd0, 6'd9};

    initial begin
        do_reset();
        // Reset state
        chk("rst_valid_o",      {31'd0, valid_o},        32'd0);
        chk("rst_is_branch_o",  {31'd0, is_branch_o},    32'd0);
        chk("rst_branch_res_o", {31'd0, branch_res_o},   32'd0);
        chk("rst_mispredict_o", {31'd0, mispredict_o},   32'd0);
        chk("rst_lookup_40",    {31'd0, lookup_taken_o}, 32'd0);

        // beq taken, predicted not-taken, then a wrong-path instruction
        step(1'b1, BEQ, 32'h5, 32'h5, 32'h40, 1'b0);
        chk("beq_mispredict", {31'd0, mispredict_o}, 32'd1);
        step(1'b1, BNE, 32'h1, 32'h2, 32'h40, 1'b0);
        chk("squash_valid", {31'd0, valid_o}, 32'd0);
        step(1'b0, BEQ, 32'h0, 32'h0, 32'h40, 1'b0);
        chk("lookup_40_after", {31'd0, lookup_taken_o}, 32'd1);

        // Signed compare corners
        step(1'b1, BLTZ, 32'hFFFFFFFF, 32'h0, 32'h48, 1'b1);
        chk("bltz_neg_taken", {31'd0, branch_res_o}, 32'd1);
        step(1'b1, BLE, 32'hFFFFFFFE, 32'h1, 32'h4C, 1'b1);
        chk("ble_signed_taken", {31'd0, branch_res_o}, 32'd1);
        step(1'b1, BGT, 32'h80000000, 32'h0, 32'h50, 1'b0);
        chk("bgt_min_not_taken", {31'd0, branch_res_o}, 32'd0);
        step(1'b1, 6'd0, 32'h1, 32'h1, 32'h54, 1'b1);
        chk("nonbranch_is_br", {31'd0, is_branch_o}, 32'd0);

        // Saturation at 0x44 with same-cycle lookup of the updated entry
        repeat (4) step(1'b1, BEQ, 32'h7, 32'h7, 32'h44, 1'b1);
        chk("bht_44_sat", bht_m[1], 32'd3);
        step(1'b0, BEQ, 32'h0, 32'h0, 32'h44, 1'b0);

        // Random mixed stream
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 6)],
                 vals[$urandom_range(0, 5)], vals[$urandom_range(0, 5)],
                 32'h40 + (32'($urandom_range(0, 15)) << 2), 1'($urandom_range(0, 1)));

`ifdef BRU_PERF_CNT_EN
        clr_req = 1'b1;
        step(1'b0, BEQ, 32'h0, 32'h0, 32'h40, 1'b0);
        clr_req = 1'b0;
        step(1'b0, BEQ, 32'h0, 32'h0, 32'h40, 1'b0);
        step(1'b1, BEQ, 32'h3, 32'h3, 32'h60, 1'b1);
        step(1'b1, BNE, 32'h3, 32'h4, 32'h64, 1'b1);
        step(1'b1, BGT, 32'h1, 32'h2, 32'h68, 1'b1);
        chk("perf_br3",  br_cnt_o,  32'd3);
        chk("perf_mis1", mis_cnt_o, 32'd1);
        step(1'b0, BEQ, 32'h0, 32'h0, 32'h60, 1'b0);
        clr_req = 1'b1;
        step(1'b1, BEQ, 32'h3, 32'h3, 32'h60, 1'b0);
        clr_req = 1'b0;
        chk("perf_clr_br",  br_cnt_o,  32'd0);
        chk("perf_clr_mis", mis_cnt_o, 32'd0);
        step(1'b0, BEQ, 32'h0, 32'h0, 32'h60, 1'b0);
`endif

        // Reset mid-stream drops the in-flight result and reinitialises the BHT
        step(1'b1, BEQ, 32'h2, 32'h2, 32'h40, 1'b1);
        step(1'b1, BEQ, 32'h2, 32'h2, 32'h40, 1'b1);
        valid_i = 1'b1; instr_op_i = BEQ; src1_i = 32'h9; src2_i = 32'h9;
        pc_i = 32'h40; pred_taken_i = 1'b0; lookup_pc_i = 32'h40; rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid_o",      {31'd0, valid_o},        32'd0);
        chk("midrst_branch_res_o", {31'd0, branch_res_o},   32'd0);
        chk("midrst_mispredict_o", {31'd0, mispredict_o},   32'd0);
        chk("midrst_lookup_40",    {31'd0, lookup_taken_o}, 32'd0);
        rst_i = 1'b0;
        model_reset();
        step(1'b1, BLTZ, 32'h1, 32'h0, 32'h40, 1'b0);
        step(1'b0, BEQ, 32'h0, 32'h0, 32'h40, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
